stage_if: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline; producer side of the IF/ID pipeline register.
- Holds the PC and fetches each 32-bit instruction as four byte reads from the memory controller's 8-bit port.
- Presents {pc, inst, busy} to the IF/ID register and handles branch redirects from later stages.

---
 rtl/stage_if_pkg.sv | 20 ++
 rtl/stage_if_icache_dm.sv | 48 ++++
 rtl/stage_if.sv | 169 ++++++++++++++++
 tb/tb_stage_if.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package stage_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_e;

  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam int unsigned INST_BYTES       = 32'd4;
  localparam int unsigned ICACHE_IDX_W_DEF = 32'd6;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/stage_if_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup,
// single-cycle fill. Only instantiated by stage_if when ICACHE_EN is defined.
module icache_dm #(
  parameter int unsigned IDX_W = 32'd6
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [29:0] word_addr,
  output logic        hit,
  output logic [31:0] rdata,
  input  logic        fill_en,
  input  logic [31:0] fill_data
);

  localparam int unsigned LINES = 32'd1 << IDX_W;
  localparam int unsigned TAG_W = 32'd30 - IDX_W;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;

  assign idx_s = word_addr[IDX_W-1:0];
  assign tag_s = word_addr[29:IDX_W];
  assign hit   = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign rdata = data_r[idx_s];

  // Valid bits: the only cache state that needs a reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays are written on fill only.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= fill_data;
    end
  end

endmodule

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: assembles each word from four byte reads.
// Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        br_taken_in,
  input  logic [31:0] br_target_in,
  output logic        mc_req_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_grant_in,
  input  logic        mc_valid_in,
  input  logic [7:0]  mc_data_in,
  output logic [31:0] if_inst_pc,
  output logic [31:0] if_inst,
  output logic        busy_out
);

  state_e      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [1:0]  byte_cnt_r, byte_cnt_s;
  logic        kill_r, kill_s;
  logic [23:0] inst_buf_r, inst_buf_s;
  logic [31:0] if_inst_pc_r, if_inst_pc_s;
  logic [31:0] if_inst_r, if_inst_s;
  logic        accept_s;
  logic        cache_hit_s;
  logic [31:0] cache_data_s;

`ifdef ICACHE_EN
  logic cache_raw_hit_s;

  icache_dm #(.IDX_W(ICACHE_IDX_W)) u_icache (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .word_addr (pc_r[31:2]),
    .hit       (cache_raw_hit_s),
    .rdata     (cache_data_s),
    .fill_en   ((state_r == S_WAIT) && (state_s == S_VALID)),
    .fill_data (if_inst_s)
  );

  // Lookups only count at the start of a fetch, never mid-word.
  assign cache_hit_s = cache_raw_hit_s && (byte_cnt_r == 2'd0);
`else
  assign cache_hit_s  = 1'b0;
  assign cache_data_s = ZERO_WORD;
`endif

  assign accept_s    = rdy_in & ~stall_in & ~br_taken_in;
  assign mc_req_out  = (state_r == S_REQ) & ~cache_hit_s;
  assign mc_addr_out = (state_r == S_REQ) ? (pc_r + {30'd0, byte_cnt_r}) : ZERO_WORD;
  assign busy_out    = (state_r != S_VALID) | br_taken_in;
  assign if_inst_pc  = if_inst_pc_r;
  assign if_inst     = if_inst_r;

  // Next-state logic: freeze on !rdy_in, redirect first, then the fetch sequence.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    byte_cnt_s   = byte_cnt_r;
    kill_s       = kill_r;
    inst_buf_s   = inst_buf_r;
    if_inst_pc_s = if_inst_pc_r;
    if_inst_s    = if_inst_r;
    if (!rdy_in) begin
      state_s = state_r;
    end else if (br_taken_in) begin
      pc_s       = word_align(br_target_in);
      byte_cnt_s = 2'd0;
      case (state_r)
        // A byte landing in the redirect cycle is simply dropped; otherwise wait it out.
        S_WAIT: begin
          if (mc_valid_in) begin
            state_s = S_REQ;
            kill_s  = 1'b0;
          end else begin
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end
        end
        S_REQ: begin
          if (mc_grant_in && !cache_hit_s) begin
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end
        default: state_s = S_REQ;
      endcase
    end else begin
      case (state_r)
        S_IDLE: state_s = S_REQ;
        S_REQ: begin
          if (cache_hit_s) begin
            state_s      = S_VALID;
            if_inst_pc_s = pc_r;
            if_inst_s    = cache_data_s;
          end else if (mc_grant_in) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (!mc_valid_in) begin
            state_s = S_WAIT;
          end else if (kill_r) begin
            state_s    = S_REQ;
            kill_s     = 1'b0;
            byte_cnt_s = 2'd0;
          end else if (byte_cnt_r == 2'd3) begin
            state_s      = S_VALID;
            byte_cnt_s   = 2'd0;
            if_inst_pc_s = pc_r;
            if_inst_s    = {mc_data_in, inst_buf_r};
          end else begin
            state_s    = S_REQ;
            byte_cnt_s = byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0:    inst_buf_s[7:0]   = mc_data_in;
              2'd1:    inst_buf_s[15:8]  = mc_data_in;
              2'd2:    inst_buf_s[23:16] = mc_data_in;
              default: inst_buf_s        = inst_buf_r;
            endcase
          end
        end
        S_VALID: begin
          if (accept_s) begin
            state_s = S_REQ;
            pc_s    = pc_r + INST_BYTES;
          end else begin
            state_s = S_VALID;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Stage state and presented instruction registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      byte_cnt_r   <= 2'd0;
      kill_r       <= 1'b0;
      inst_buf_r   <= 24'd0;
      if_inst_pc_r <= ZERO_WORD;
      if_inst_r    <= ZERO_WORD;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      byte_cnt_r   <= byte_cnt_s;
      kill_r       <= kill_s;
      inst_buf_r   <= inst_buf_s;
      if_inst_pc_r <= if_inst_pc_s;
      if_inst_r    <= if_inst_s;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if (default build): byte-serving memory model,
// directed fetch/stall/freeze/redirect/wrap sequence, monitor on each accepted instruction.
module tb_stage_if;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, stall_in, br_taken_in;
  logic [31:0] br_target_in;
  logic        mc_req_out;
  logic [31:0] mc_addr_out;
  logic        mc_grant_in, mc_valid_in;
  logic [7:0]  mc_data_in;
  logic [31:0] if_inst_pc, if_inst;
  logic        busy_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  mem [bit [31:0]];
  int          mem_lat = 1;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  bit          live;

  always #5 clk_in = ~clk_in;

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .br_taken_in(br_taken_in), .br_target_in(br_target_in),
    .mc_req_out(mc_req_out), .mc_addr_out(mc_addr_out), .mc_grant_in(mc_grant_in),
    .mc_valid_in(mc_valid_in), .mc_data_in(mc_data_in),
    .if_inst_pc(if_inst_pc), .if_inst(if_inst), .busy_out(busy_out)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void load_word(input logic [31:0] a, input logic [31:0] w);
    mem[a]         = w[7:0];
    mem[a + 32'd1] = w[15:8];
    mem[a + 32'd2] = w[23:16];
    mem[a + 32'd3] = w[31:24];
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_busy_low(input string name);
    int n = 0;
    while (busy_out !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_presented"}, {31'd0, busy_out}, 32'd0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (mc_req_out !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_req"}, {31'd0, mc_req_out}, 32'd1);
  endtask

  task automatic wait_req_addr(input logic [31:0] addr, input string name);
    int n = 0;
    while (!(mc_req_out === 1'b1 && mc_addr_out === addr) && n < 300) begin
      tick();
      n++;
    end
    chk(name, mc_addr_out, addr);
  endtask

  // Memory controller model: one grant per request, response mem_lat live cycles later.
  initial begin
    mc_grant_in = 1'b0;
    mc_valid_in = 1'b0;
    mc_data_in  = 8'h00;
    forever begin
      @(posedge clk_in);
      live = rdy_in;
      #2;
      if (live) begin
        mc_grant_in = 1'b0;
        mc_valid_in = 1'b0;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            mc_valid_in = 1'b1;
            mc_data_in  = mem_rd(pend_addr);
          end
        end else if (mc_req_out === 1'b1 && rst_n_in) begin
          mc_grant_in = 1'b1;
          pend_addr   = mc_addr_out;
          lat_cnt     = mem_lat;
        end
      end
    end
  end

  // Monitor: every instruction consumed by IF/ID is matched against the scoreboard.
  always @(negedge clk_in) begin
    if (rst_n_in && busy_out === 1'b0 && rdy_in && !stall_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h, expected none", if_inst_pc, if_inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("inst_pc", if_inst_pc, e[63:32]);
        chk("inst", if_inst, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n_in     = 1'b0;
    rdy_in       = 1'b1;
    stall_in     = 1'b1;
    br_taken_in  = 1'b0;
    br_target_in = 32'd0;
    load_word(32'h0000_0000, 32'h0050_0013);
    load_word(32'h0000_0004, 32'h00A0_0093);
    load_word(32'h0000_0008, 32'h0000_0013);
    load_word(32'h0000_1000, 32'h1234_5678);
    load_word(32'h0000_1004, 32'hCAFE_BABE);
    load_word(32'hFFFF_FFFC, 32'hDEAD_BEEF);

    repeat (3) tick();
    chk("rst_busy", {31'd0, busy_out}, 32'd1);
    chk("rst_req", {31'd0, mc_req_out}, 32'd0);
    chk("rst_addr", mc_addr_out, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_pc", if_inst_pc, 32'd0);

    // First fetch at 0, then hold in S_VALID under stall.
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    rst_n_in = 1'b1;
    wait_busy_low("fetch0");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_busy", {31'd0, busy_out}, 32'd0);
      chk("stall_inst", if_inst, 32'h0050_0013);
      chk("stall_req", {31'd0, mc_req_out}, 32'd0);
    end
    exp_q.push_back({32'h0000_0004, 32'h00A0_0093});
    stall_in = 1'b0;
    tick();
    chk("next_req", {31'd0, mc_req_out}, 32'd1);
    chk("next_addr", mc_addr_out, 32'h0000_0004);

    // Global freeze while requesting byte 2 of the word at 4.
    wait_req_addr(32'h0000_0006, "freeze_start_addr");
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_addr", mc_addr_out, 32'h0000_0006);
      chk("freeze_req", {31'd0, mc_req_out}, 32'd1);
      chk("freeze_busy", {31'd0, busy_out}, 32'd1);
    end
    rdy_in = 1'b1;
    wait_busy_low("fetch4");
    mem_lat = 3;

    // Redirect while byte 2 of the word at 8 is in flight.
    exp_q.push_back({32'h0000_1000, 32'h1234_5678});
    wait_req_addr(32'h0000_000A, "byte2_addr");
    tick();
    chk("inflight_req", {31'd0, mc_req_out}, 32'd0);
    br_taken_in  = 1'b1;
    br_target_in = 32'h0000_1003;
    tick();
    br_taken_in = 1'b0;
    mem_lat     = 2;
    chk("kill_busy", {31'd0, busy_out}, 32'd1);
    chk("kill_wait_req", {31'd0, mc_req_out}, 32'd0);
    wait_req("redirect");
    chk("redirect_addr", mc_addr_out, 32'h0000_1000);
    wait_busy_low("fetch1000");
    tick();

    // Redirect from S_VALID: busy forced high, then fetch at the top of memory.
    stall_in = 1'b1;
    wait_busy_low("fetch1004");
    chk("hold_inst", if_inst, 32'hCAFE_BABE);
    chk("hold_pc", if_inst_pc, 32'h0000_1004);
    br_taken_in  = 1'b1;
    br_target_in = 32'hFFFF_FFFE;
    #3;
    chk("redirect_busy", {31'd0, busy_out}, 32'd1);
    tick();
    br_taken_in = 1'b0;
    stall_in    = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    chk("top_req", {31'd0, mc_req_out}, 32'd1);
    chk("top_addr", mc_addr_out, 32'hFFFF_FFFC);
    wait_busy_low("fetch_top");
    tick();
    chk("wrap_req", {31'd0, mc_req_out}, 32'd1);
    chk("wrap_addr", mc_addr_out, 32'h0000_0000);
    wait_busy_low("fetch_wrap");
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
